// File: rtl/md_ctrl.sv
// Multiply/divide unit for the ID stage: single-cycle multiply into HI/LO and a
// 32-cycle restoring divider that stalls IF/ID until the result is ready.
module md_ctrl #(
  parameter logic [5:0] OP_MULT  = 6'b011000,
  parameter logic [5:0] OP_MULTU = 6'b011001,
  parameter logic [5:0] OP_DIV   = 6'b011010,
  parameter logic [5:0] OP_DIVU  = 6'b011011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [31:0] regaData,
  input  logic [31:0] regbData,
  input  logic        annul,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        divZero
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] divisor, rem, quo;
  logic        q_neg, r_neg, div_zero_r;
  logic        stall_c;

  logic        is_mul, is_div, div_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] prod;
  logic [32:0] tmp;
  logic        fits;
  logic [31:0] rem_step, quo_step, q_final, r_final;

  assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
  assign div_signed = (op == OP_DIV);

  // The divider always works on magnitudes; signs are reapplied on the last step.
  assign abs_a = (div_signed && regaData[31]) ? (~regaData + 32'd1) : regaData;
  assign abs_b = (div_signed && regbData[31]) ? (~regbData + 32'd1) : regbData;

  assign prod = (op == OP_MULT)
              ? ({{32{regaData[31]}}, regaData} * {{32{regbData[31]}}, regbData})
              : ({32'd0, regaData} * {32'd0, regbData});

  assign tmp      = {rem, quo[31]};
  assign fits     = tmp >= {1'b0, divisor};
  assign rem_step = fits ? (tmp[31:0] - divisor) : tmp[31:0];
  assign quo_step = {quo[30:0], fits};
  assign q_final  = q_neg ? (~quo_step + 32'd1) : quo_step;
  assign r_final  = r_neg ? (~rem_step + 32'd1) : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (!annul && is_div) begin
          stall_c   = 1'b1;
          state_nxt = (regbData == 32'd0) ? DONE : DIV;
        end
      end
      DIV: begin
        if (annul) begin
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
          if (cnt == 6'd31) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is forced low during reset even though op may still hold a divide.
  assign stall   = rst && stall_c;
  assign done    = (state == DONE);
  assign divZero = done && div_zero_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi         <= 32'd0;
      lo         <= 32'd0;
      cnt        <= 6'd0;
      divisor    <= 32'd0;
      rem        <= 32'd0;
      quo        <= 32'd0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!annul) begin
            if (is_mul) begin
              {hi, lo} <= prod;
            end else if (is_div) begin
              if (regbData == 32'd0) begin
                hi         <= regaData;
                lo         <= 32'hFFFF_FFFF;
                div_zero_r <= 1'b1;
              end else begin
                rem        <= 32'd0;
                quo        <= abs_a;
                divisor    <= abs_b;
                q_neg      <= div_signed && (regaData[31] ^ regbData[31]);
                r_neg      <= div_signed && regaData[31];
                cnt        <= 6'd0;
                div_zero_r <= 1'b0;
              end
            end
          end
        end
        DIV: begin
          if (!annul) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              hi <= r_final;
              lo <= q_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: stimulus queues expected HI/LO/done events, a
// negedge monitor pops one whenever done rises or HI/LO change.
module tb_md_ctrl;

  localparam logic [5:0] NOP   = 6'b000000;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic        clk, rst, annul, stall, done, divZero;
  logic [5:0]  op;
  logic [31:0] regaData, regbData, hi, lo;

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [63:0] prev;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  md_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .regaData(regaData), .regbData(regbData),
    .annul(annul), .stall(stall), .hi(hi), .lo(lo), .done(done), .divZero(divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic waitEdge;
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction, holds it while stalled, and queues the expected result.
  task automatic applyStimulus(input string name, input logic [5:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int lat, input int exp_stall,
                               input logic [31:0] eh, input logic [31:0] el, input logic ez);
    exp_t e;
    int   n;
    op = o; regaData = a; regbData = b;
    e.tag = name; e.cyc = cyc + lat; e.hi = eh; e.lo = el; e.dz = ez;
    expq.push_back(e);
    #1;
    n = 0;
    while (stall && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    @(posedge clk);
    #1;
    op = NOP;
    waitEdge;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev = '0;
    end else begin
      if (done || ({hi, lo} != prev)) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got hi=%h lo=%h done=%b want no output", hi, lo, done);
        end else begin
          mon_e = expq.pop_front();
          checkOutput({mon_e.tag, "_cycle"},   64'(cyc), 64'(mon_e.cyc));
          checkOutput({mon_e.tag, "_hi"},      {32'd0, hi}, {32'd0, mon_e.hi});
          checkOutput({mon_e.tag, "_lo"},      {32'd0, lo}, {32'd0, mon_e.lo});
          checkOutput({mon_e.tag, "_done"},    {63'd0, done}, {63'd0, mon_e.cyc != 0 && (mon_e.tag.substr(0, 2) == "div")});
          checkOutput({mon_e.tag, "_divZero"}, {63'd0, divZero}, {63'd0, mon_e.dz});
        end
      end
      prev = {hi, lo};
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b0; annul = 1'b0; op = DIV; regaData = 32'd5; regbData = 32'd3;
    #12;
    checkOutput("reset_hi",      {32'd0, hi},      64'd0);
    checkOutput("reset_lo",      {32'd0, lo},      64'd0);
    checkOutput("reset_done",    {63'd0, done},    64'd0);
    checkOutput("reset_divZero", {63'd0, divZero}, 64'd0);
    checkOutput("reset_stall",   {63'd0, stall},   64'd0);
    waitEdge;
    rst = 1'b1; op = NOP;
    waitEdge;

    applyStimulus("mul_multu_ffff_x2", MULTU, 32'hFFFF_FFFF, 32'd2, 1, 0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    applyStimulus("mul_mult_m3_x5",    MULT,  32'hFFFF_FFFD, 32'd5, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    applyStimulus("div_m7_by_2",       DIV,   32'hFFFF_FFF9, 32'd2, 33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("div_u100_by_0",     DIVU,  32'd100, 32'd0, 1, 1, 32'd100, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("div_minint_by_m1",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 33, 32'd0, 32'h8000_0000, 1'b0);
    applyStimulus("div_100_by_m7",     DIV,   32'd100, 32'hFFFF_FFF9, 33, 33, 32'd2, 32'hFFFF_FFF2, 1'b0);

    // Annul a running divide at DIV cycle 10.
    op = DIVU; regaData = 32'd1000; regbData = 32'd7;
    #1;
    checkOutput("annul_div_start_stall", {63'd0, stall}, 64'd1);
    repeat (11) waitEdge;
    annul = 1'b1;
    #1;
    checkOutput("annul_div_stall", {63'd0, stall}, 64'd0);
    waitEdge;
    annul = 1'b0; op = NOP;
    #1;
    checkOutput("annul_div_idle_stall", {63'd0, stall}, 64'd0);
    repeat (40) waitEdge;
    checkOutput("annul_div_hi", {32'd0, hi}, 64'd2);
    checkOutput("annul_div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF2);

    // Annul in IDLE suppresses both a multiply write and a divide start.
    annul = 1'b1; op = MULT; regaData = 32'd3; regbData = 32'd3;
    #1;
    checkOutput("annul_idle_mult_stall", {63'd0, stall}, 64'd0);
    waitEdge;
    op = DIV; regaData = 32'd5; regbData = 32'd1;
    #1;
    checkOutput("annul_idle_div_stall", {63'd0, stall}, 64'd0);
    waitEdge;
    annul = 1'b0; op = NOP;
    repeat (40) waitEdge;

    applyStimulus("div_u1000_by_7",   DIVU,  32'd1000, 32'd7, 33, 33, 32'd6, 32'h0000_008E, 1'b0);
    applyStimulus("mul_multu_big",    MULTU, 32'h1234_5678, 32'h10, 1, 0, 32'h0000_0001, 32'h2345_6780, 1'b0);

    // Reset in the middle of a divide: outputs clear without a clock edge.
    op = DIV; regaData = 32'hFFFF_FFF9; regbData = 32'd2;
    repeat (21) waitEdge;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_hi",      {32'd0, hi},      64'd0);
    checkOutput("midreset_lo",      {32'd0, lo},      64'd0);
    checkOutput("midreset_done",    {63'd0, done},    64'd0);
    checkOutput("midreset_divZero", {63'd0, divZero}, 64'd0);
    checkOutput("midreset_stall",   {63'd0, stall},   64'd0);
    op = NOP;
    waitEdge;
    waitEdge;
    rst = 1'b1;
    repeat (40) waitEdge;
    checkOutput("post_reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("post_reset_done",  {63'd0, done},  64'd0);

    applyStimulus("mul_after_reset", MULT, 32'd6, 32'd7, 1, 0, 32'd0, 32'd42, 1'b0);
    repeat (3) waitEdge;

    checkOutput("queue_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous reset, active-low (`RstEnable`); asserting forces reset state immediately, independent of clk.
REQ-003 op  input  6  decoded op from ID; acts only on `Mult`, `Multu`, `Div`, `Divu`; all other codes are treated as no operation.
REQ-004 regaData  input  32  rs operand: multiplicand or dividend.
REQ-005 regbData  input  32  rt operand: multiplier or divisor.
REQ-006 annul  input  1  synchronous cancel of any in-flight or starting operation.
REQ-007 stall  output  1  combinational; high = IF/ID must hold the current instruction.
REQ-008 hi  output  32  HI register: product[63:32] or remainder.
REQ-009 lo  output  32  LO register: product[31:0] or quotient.
REQ-010 done  output  1  high for exactly the single DONE cycle.
REQ-011 divZero  output  1  high during DONE when the divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DIV, DONE.
REQ-013 In IDLE with annul=0, op=Mult/Multu SHALL load {hi,lo} with the signed/unsigned 64-bit product at the next edge, with stall=0 and the FSM remaining in IDLE.
REQ-014 In IDLE with annul=0, op=Div/Divu and regbData!=0 SHALL capture the operands and signedness, clear the 6-bit iteration counter and go to DIV.
REQ-015 In IDLE with annul=0, op=Div/Divu and regbData==0 SHALL go directly to DONE, loading hi=regaData, lo=32'hFFFFFFFF and setting divZero=1 for the DONE cycle.
REQ-016 Signed divide SHALL run on absolute values in 32-bit unsigned form; quotient is negated when operand signs differ; remainder takes the sign of the dividend.
REQ-017 0x80000000 / 0xFFFFFFFF (signed) SHALL yield lo=0x80000000, hi=0 with no exception flag.
REQ-018 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (counter 0..31).
REQ-019 The edge ending counter=31 SHALL load hi/lo with the sign-corrected results and enter DONE.
REQ-020 stall SHALL equal (state==IDLE && annul==0 && op in {Div,Divu}) || (state==DIV && annul==0).
REQ-021 In DONE: stall=0, done=1; op is ignored, so the same instruction still held in ID cannot restart a divide; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-022 Latency: a divide whose instruction is in ID at cycle 0 SHALL assert stall in cycles 0-32 and reach DONE in cycle 33, with results visible on hi/lo from cycle 33.
REQ-023 annul=1 in DIV SHALL return the FSM to IDLE at the next edge without modifying hi/lo; done SHALL not assert.
REQ-024 annul=1 in IDLE SHALL suppress any start and any multiply write.
REQ-025 hi/lo SHALL change only per REQ-013, REQ-015, REQ-019 and reset; ops arriving while in DIV or DONE SHALL have no effect.

Reset
REQ-026 While rst is asserted: state=IDLE, counter=0, internal operand registers=0, hi=0, lo=0, done=0, divZero=0, stall=0.
REQ-027 Reset asserted mid-divide SHALL abandon the operation; after release the FSM SHALL wait in IDLE for a new op.

Verification
REQ-028 Multu with 0xFFFFFFFF x 2 -> next cycle hi=0x00000001, lo=0xFFFFFFFE; stall never high.
REQ-029 Mult with 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-030 Div with 0xFFFFFFF9 (-7) / 2 -> stall high 33 cycles; then done=1 for 1 cycle with lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 Divu with 100 / 0 -> stall high 1 cycle; next cycle done=1, divZero=1, hi=100, lo=0xFFFFFFFF.
REQ-032 Divu 1000/7 with annul pulsed in DIV cycle 10 -> stall low from that cycle, FSM back in IDLE, hi/lo keep their prior values, no done pulse.
REQ-033 Div in progress with rst driven low at DIV cycle 20 -> all outputs 0 immediately without a clk edge; after release the FSM stays in IDLE while op=Nop.
